md_stall_ctrl: RTL and testbench
================================

Name: md_stall_ctrl

Overview:
- Pipeline-freeze controller for the F/D front end and the multiply/divide (HI/LO) unit.
- Tracks the mult/div busy window with a down-counter.
- Merges that window with the hazard unit's data-hazard stall to produce:
  - the PC-register write enable,
  - the D-register write enable,
  - the E-register flush.
- Sits between the hazard unit, the E-stage mult/div unit, and the F/D pipeline registers.

Parameters:
- MULT_CYCLES, 5, busy cycles after start for mult/multu (1..15).
- DIV_CYCLES, 10, busy cycles after start for div/divu (1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  E-stage mult/div start pulse, one cycle per instruction.
- md_op  input  2  operation qualifying start: 00 mult, 01 multu, 10 div, 11 divu.
- md_use_D  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- hz_stall  input  1  data-hazard stall request from the hazard unit.
- busy  output  1  mult/div unit occupied (registered).
- count  output  4  remaining busy cycles (registered).
- done  output  1  one-cycle pulse in the cycle busy falls; used as the HI/LO write strobe.
- stall  output  1  combined stall.
- pc_we  output  1  PC register write enable.
- d_we  output  1  F/D register write enable.
- e_flush  output  1  D/E register flush (bubble insert).
- err  output  1  sticky flag: start seen while busy.

Behaviour:
- Reset (reset==0 at a rising edge), which wins over every other input:
  - count=0, busy=0, done=0, err=0.
  - Combinational outputs then follow their equations with busy=0.
- States:
  - IDLE (busy=0) and BUSY (busy=1).
  - busy is a register, not derived combinationally from count.
- IDLE, start=1: load count with MULT_CYCLES when md_op[1]==0, else DIV_CYCLES; set busy=1; go to BUSY.
- IDLE, start=0: hold; count stays 0.
- BUSY, each cycle: count=count-1.
- BUSY, count==1: next cycle count=0, busy=0, done=1 for exactly that cycle; go to IDLE.
- Busy window:
  - busy is high for exactly N consecutive cycles following the start cycle (N = MULT_CYCLES or DIV_CYCLES).
  - done rises on the first cycle with busy=0.
- BUSY, start=1 (illegal; the hazard logic must prevent it):
  - start is ignored and the countdown continues unchanged.
  - err sets on the next edge and stays set until reset.
- count never wraps: decrement only when busy=1 and count!=0.
- Combinational equations:
  - md_stall = md_use_D & (start | busy).
  - stall = hz_stall | md_stall.
  - pc_we = ~stall; d_we = ~stall; e_flush = stall.
- hz_stall only affects the combinational outputs. It never alters count, busy or the state.
- The start cycle itself stalls a dependent D-stage instruction, so there is zero-cycle exposure.
- Back-to-back: start may be accepted in the same cycle done=1, because busy is 0 then. This reloads count, and busy stays 0→1 with no gap cycle beyond done.
- Reset mid-operation abandons the countdown. No done pulse is generated.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1, md_op=10 → busy=0, count=0, done=0, err=0, pc_we=1, e_flush=0.
- Mult countdown:
  - Stimulus: start=1 with md_op=00 in cycle 0; md_use_D=1 throughout.
  - Required: stall=1 in cycle 0; busy=1 with count=5,4,3,2,1 in cycles 1–5.
  - Required: cycle 6 has busy=0, count=0, done=1, stall=0, pc_we=1. done=0 in cycle 7.
- Div without dependency:
  - Stimulus: start=1 with md_op=11; md_use_D=0; hz_stall=0.
  - Required: busy high for 10 cycles; pc_we=1 and e_flush=0 throughout; a single done pulse on cycle 11.
- Hazard merge:
  - Stimulus: IDLE, hz_stall=1 for 3 cycles.
  - Required: stall=1, pc_we=0, d_we=0, e_flush=1 for those 3 cycles; count and busy unchanged at 0.
- Illegal and back-to-back starts:
  - Illegal: start again at count=3 → countdown continues 2,1,0; err=1 from the next cycle until reset.
  - Back-to-back: start in the done cycle with md_op=01 → count=5 next cycle, busy=1.
- Reset mid-op: reset=0 while div count=6 → next cycle busy=0, count=0; no done pulse in any later cycle.

Source files
------------

// File: rtl/md_stall_ctrl.sv
// Freeze controller for the F/D front end and the HI/LO multiply/divide unit.
// Counts down the mult/div busy window and merges it with the data-hazard stall.
module md_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] md_op,
    input  logic       md_use_D,
    input  logic       hz_stall,
    output logic       busy,
    output logic [3:0] count,
    output logic       done,
    output logic       stall,
    output logic       pc_we,
    output logic       d_we,
    output logic       e_flush,
    output logic       err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       md_stall;

    // Signed and unsigned variants share the same latency, so md_op[0] is not needed.
    logic unused_md_op;
    assign unused_md_op = md_op[0];

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = md_op[1] ? DIV_LOAD : MULT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A start while busy is ignored apart from latching the error flag.
                if (start) begin
                    err_d = 1'b1;
                end
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end
                if (count_q <= 4'd1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // The start cycle itself stalls a dependent D-stage instruction.
    assign md_stall = md_use_D & (start | busy);
    assign busy     = (state_q == BUSY);
    assign count    = count_q;
    assign done     = done_q;
    assign err      = err_q;
    assign stall    = hz_stall | md_stall;
    assign pc_we    = ~stall;
    assign d_we     = ~stall;
    assign e_flush  = stall;

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Directed bench for md_stall_ctrl: countdowns, hazard merge, illegal start,
// back-to-back start and mid-operation reset.
module tb_md_stall_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] md_op;
    logic       md_use_D;
    logic       hz_stall;
    logic       busy;
    logic [3:0] count;
    logic       done;
    logic       stall;
    logic       pc_we;
    logic       d_we;
    logic       e_flush;
    logic       err;

    int vec_count   = 0;
    int miscompares = 0;

    md_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .md_use_D (md_use_D),
        .hz_stall (hz_stall),
        .busy     (busy),
        .count    (count),
        .done     (done),
        .stall    (stall),
        .pc_we    (pc_we),
        .d_we     (d_we),
        .e_flush  (e_flush),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one rising edge and settle just after it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vec_count++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b1;
        md_op    = 2'b10;
        md_use_D = 1'b0;
        hz_stall = 1'b0;
        #1;
        applyStimulus();
        applyStimulus();

        // Reset wins over start
        checkOutput("rst_busy", {3'b0, busy}, 4'd0);
        checkOutput("rst_count", count, 4'd0);
        checkOutput("rst_done", {3'b0, done}, 4'd0);
        checkOutput("rst_err", {3'b0, err}, 4'd0);
        checkOutput("rst_pc_we", {3'b0, pc_we}, 4'd1);
        checkOutput("rst_e_flush", {3'b0, e_flush}, 4'd0);
        reset = 1'b1;
        start = 1'b0;
        applyStimulus();

        // Mult countdown with a dependent D-stage instruction
        start    = 1'b1;
        md_op    = 2'b00;
        md_use_D = 1'b1;
        #1;
        checkOutput("mult_c0_stall", {3'b0, stall}, 4'd1);
        checkOutput("mult_c0_busy", {3'b0, busy}, 4'd0);
        applyStimulus();
        start = 1'b0;
        #1;
        for (int i = 1; i <= 5; i++) begin
            checkOutput("mult_busy", {3'b0, busy}, 4'd1);
            checkOutput("mult_count", count, 4'(6 - i));
            checkOutput("mult_stall", {3'b0, stall}, 4'd1);
            checkOutput("mult_done", {3'b0, done}, 4'd0);
            applyStimulus();
        end
        checkOutput("mult_c6_busy", {3'b0, busy}, 4'd0);
        checkOutput("mult_c6_count", count, 4'd0);
        checkOutput("mult_c6_done", {3'b0, done}, 4'd1);
        checkOutput("mult_c6_stall", {3'b0, stall}, 4'd0);
        checkOutput("mult_c6_pc_we", {3'b0, pc_we}, 4'd1);
        applyStimulus();
        checkOutput("mult_c7_done", {3'b0, done}, 4'd0);

        // Divu without a dependent instruction
        start    = 1'b1;
        md_op    = 2'b11;
        md_use_D = 1'b0;
        #1;
        checkOutput("div_c0_pc_we", {3'b0, pc_we}, 4'd1);
        checkOutput("div_c0_e_flush", {3'b0, e_flush}, 4'd0);
        applyStimulus();
        start = 1'b0;
        #1;
        for (int i = 1; i <= 10; i++) begin
            checkOutput("div_busy", {3'b0, busy}, 4'd1);
            checkOutput("div_count", count, 4'(11 - i));
            checkOutput("div_pc_we", {3'b0, pc_we}, 4'd1);
            checkOutput("div_e_flush", {3'b0, e_flush}, 4'd0);
            checkOutput("div_done", {3'b0, done}, 4'd0);
            applyStimulus();
        end
        checkOutput("div_c11_busy", {3'b0, busy}, 4'd0);
        checkOutput("div_c11_done", {3'b0, done}, 4'd1);
        applyStimulus();
        checkOutput("div_c12_done", {3'b0, done}, 4'd0);

        // Hazard stall alone while idle
        hz_stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("hz_stall", {3'b0, stall}, 4'd1);
            checkOutput("hz_pc_we", {3'b0, pc_we}, 4'd0);
            checkOutput("hz_d_we", {3'b0, d_we}, 4'd0);
            checkOutput("hz_e_flush", {3'b0, e_flush}, 4'd1);
            checkOutput("hz_count", count, 4'd0);
            checkOutput("hz_busy", {3'b0, busy}, 4'd0);
            applyStimulus();
        end
        hz_stall = 1'b0;
        #1;
        checkOutput("hz_release_pc_we", {3'b0, pc_we}, 4'd1);

        // Illegal start at count 3, then back-to-back start in the done cycle
        start = 1'b1;
        md_op = 2'b00;
        applyStimulus();
        start = 1'b0;
        checkOutput("ill_count5", count, 4'd5);
        applyStimulus();
        checkOutput("ill_count4", count, 4'd4);
        applyStimulus();
        checkOutput("ill_count3", count, 4'd3);
        start = 1'b1;
        md_op = 2'b10;
        applyStimulus();
        start = 1'b0;
        checkOutput("ill_count2", count, 4'd2);
        checkOutput("ill_err_set", {3'b0, err}, 4'd1);
        applyStimulus();
        checkOutput("ill_count1", count, 4'd1);
        checkOutput("ill_busy1", {3'b0, busy}, 4'd1);
        applyStimulus();
        checkOutput("ill_count0", count, 4'd0);
        checkOutput("ill_done", {3'b0, done}, 4'd1);
        checkOutput("ill_err_hold", {3'b0, err}, 4'd1);
        start = 1'b1;
        md_op = 2'b01;
        applyStimulus();
        start = 1'b0;
        checkOutput("b2b_count", count, 4'd5);
        checkOutput("b2b_busy", {3'b0, busy}, 4'd1);
        checkOutput("b2b_done", {3'b0, done}, 4'd0);
        checkOutput("b2b_err", {3'b0, err}, 4'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
        end
        checkOutput("b2b_end_done", {3'b0, done}, 4'd1);
        applyStimulus();

        // Reset while a div is at count 6
        start = 1'b1;
        md_op = 2'b10;
        applyStimulus();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checkOutput("mid_count", count, 4'(11 - i));
            applyStimulus();
        end
        checkOutput("mid_count6", count, 4'd6);
        reset = 1'b0;
        applyStimulus();
        reset = 1'b1;
        checkOutput("mid_busy", {3'b0, busy}, 4'd0);
        checkOutput("mid_count0", count, 4'd0);
        checkOutput("mid_err_clr", {3'b0, err}, 4'd0);
        for (int i = 0; i < 12; i++) begin
            checkOutput("mid_no_done", {3'b0, done}, 4'd0);
            applyStimulus();
        end
        checkOutput("mid_idle", {3'b0, busy}, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
